// File: rtl/speck_pkg.sv
// Shared types and helpers for the iterative SPECK encryption engine.
// Holds the FSM state type, default rotate amounts and width-generic rotate functions.
package speck_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned ALPHA_W16  = 7;
  localparam int unsigned BETA_W16   = 2;
  localparam int unsigned ALPHA_WIDE = 8;
  localparam int unsigned BETA_WIDE  = 3;

  localparam int unsigned MAX_W = 64;

  function automatic logic [MAX_W-1:0] word_mask(input int unsigned w);
    return (w >= MAX_W) ? {MAX_W{1'b1}} : ((64'd1 << w) - 64'd1);
  endfunction

  // Rotates the low w bits of v; bits above w are returned as zero. Requires s < w.
  function automatic logic [MAX_W-1:0] ror(input logic [MAX_W-1:0] v,
                                           input int unsigned w,
                                           input int unsigned s);
    logic [MAX_W-1:0] m;
    logic [MAX_W-1:0] vm;
    m  = word_mask(w);
    vm = v & m;
    return ((vm >> s) | (vm << (w - s))) & m;
  endfunction

  function automatic logic [MAX_W-1:0] rol(input logic [MAX_W-1:0] v,
                                           input int unsigned w,
                                           input int unsigned s);
    return ror(v, w, w - s);
  endfunction

endpackage

// File: rtl/speck_round.sv
// One combinational SPECK round: x' = (ROR(x,ALPHA) + y) ^ k, y' = ROL(y,BETA) ^ x'.
// Reused for the key schedule with (l[0], k, rnd) in place of (x, y, k).
module speck_round
  import speck_pkg::*;
#(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned ALPHA  = ALPHA_W16,
  parameter int unsigned BETA   = BETA_W16
) (
  input  logic [WORD_W-1:0] x_i,
  input  logic [WORD_W-1:0] y_i,
  input  logic [WORD_W-1:0] k_i,
  output logic [WORD_W-1:0] x_o,
  output logic [WORD_W-1:0] y_o
);

  logic [WORD_W-1:0] x_rot;
  logic [WORD_W-1:0] y_rot;

  assign x_rot = WORD_W'(ror(MAX_W'(x_i), WORD_W, ALPHA));
  assign y_rot = WORD_W'(rol(MAX_W'(y_i), WORD_W, BETA));

  // The add wraps modulo 2^WORD_W; the carry out is dropped by the result width.
  assign x_o = (x_rot + y_i) ^ k_i;
  assign y_o = y_rot ^ x_o;

endmodule

// File: rtl/speck_iter_core.sv
// Iterative SPECK encryption engine: one round per clock, on-the-fly key schedule,
// valid/ready on both sides. Define SPECK_DEBUG_KEY_EN to expose dbg_round_key/dbg_round.
module speck_iter_core
  import speck_pkg::*;
#(
  parameter int unsigned WORD_W    = 16,
  parameter int unsigned KEY_WORDS = 4,
  parameter int unsigned ROUNDS    = 22,
  parameter int unsigned ALPHA     = ALPHA_W16,
  parameter int unsigned BETA      = BETA_W16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2*WORD_W-1:0]           in_block,
  input  logic [KEY_WORDS*WORD_W-1:0]   in_key,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2*WORD_W-1:0]           out_block
`ifdef SPECK_DEBUG_KEY_EN
  ,
  output logic [WORD_W-1:0]             dbg_round_key,
  output logic [$clog2(ROUNDS+1)-1:0]   dbg_round
`endif
);

  localparam int unsigned CNT_W = $clog2(ROUNDS + 1);
  localparam int unsigned L_N   = KEY_WORDS - 1;
  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS - 1);

  state_e                         state_q, state_d;
  logic [WORD_W-1:0]              x_q, x_d;
  logic [WORD_W-1:0]              y_q, y_d;
  logic [WORD_W-1:0]              k_q, k_d;
  logic [L_N-1:0][WORD_W-1:0]     l_q, l_d;
  logic [CNT_W-1:0]               rnd_q, rnd_d;
  logic                           in_ready_q, in_ready_d;
  logic                           out_valid_q, out_valid_d;
  logic [2*WORD_W-1:0]            out_block_q, out_block_d;

  logic [WORD_W-1:0]              x_nxt, y_nxt;
  logic [WORD_W-1:0]              l_new, k_nxt;
  logic [WORD_W-1:0]              rnd_ext;

  assign rnd_ext = WORD_W'(rnd_q);

  speck_round #(.WORD_W(WORD_W), .ALPHA(ALPHA), .BETA(BETA)) u_data_round (
    .x_i (x_q),
    .y_i (y_q),
    .k_i (k_q),
    .x_o (x_nxt),
    .y_o (y_nxt)
  );

  // The key schedule is the same round function with the counter as the "key".
  speck_round #(.WORD_W(WORD_W), .ALPHA(ALPHA), .BETA(BETA)) u_key_round (
    .x_i (l_q[0]),
    .y_i (k_q),
    .k_i (rnd_ext),
    .x_o (l_new),
    .y_o (k_nxt)
  );

  always_comb begin
    // NOTE: every _d starts as its _q so no path through this block can infer a latch.
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    k_d         = k_q;
    l_d         = l_q;
    rnd_d       = rnd_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_block_d = out_block_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          x_d = in_block[2*WORD_W-1:WORD_W];
          y_d = in_block[WORD_W-1:0];
          k_d = in_key[WORD_W-1:0];
          for (int i = 0; i < int'(L_N); i++) begin
            l_d[i] = in_key[(i+1)*WORD_W +: WORD_W];
          end
          rnd_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end else begin
          in_ready_d = 1'b1;
        end
      end

      RUN: begin
        x_d = x_nxt;
        y_d = y_nxt;
        k_d = k_nxt;
        for (int i = 0; i < int'(L_N) - 1; i++) begin
          l_d[i] = l_q[i+1];
        end
        l_d[L_N-1] = l_new;
        rnd_d      = rnd_q + CNT_W'(1);
        if (rnd_q == LAST_RND) begin
          out_block_d = {x_nxt, y_nxt};
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: all state uses non-blocking assignments; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      k_q         <= '0;
      l_q         <= '0;
      rnd_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_block_q <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      k_q         <= k_d;
      l_q         <= l_d;
      rnd_q       <= rnd_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_block_q <= out_block_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_block = out_block_q;

`ifdef SPECK_DEBUG_KEY_EN
  // The registers keep their last values after a block; report zero whenever idle.
  assign dbg_round_key = (state_q == IDLE) ? '0 : k_q;
  assign dbg_round     = (state_q == IDLE) ? '0 : rnd_q;
`endif

endmodule
